mem_access_unit: RTL

// - Load/store front end between the datapath and the word-wide synchronous data memory (RD registered one edge after A).
// - Converts byte addresses to word indices and performs byte/half/word loads with sign or zero extension.
// - Performs sub-word stores as read-modify-write, because the memory writes whole words only.
// - Flags misaligned or out-of-range accesses without touching memory.

---
 rtl/mem_access_unit.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit
// Load/store front end between the datapath and a word-wide synchronous data
// memory (read data registered one edge after the address). Byte addresses are
// turned into word indices. Byte and half loads are sign- or zero-extended.
// Sub-word stores are done as read-modify-write, because the memory only
// writes whole words. Misaligned, illegal-size and out-of-range requests get
// an error response without touching memory.
//
// Ports
//   clk, reset            clock; asynchronous active-high reset
//   req_valid/req_ready   request handshake (ready only when idle)
//   req_write             1 = store, 0 = load
//   req_size              00 byte, 01 half, 10 word, 11 illegal
//   req_signed            loads: 1 = sign-extend, 0 = zero-extend
//   req_addr, req_wdata   byte address; store data (low bits for sub-word)
//   resp_valid/resp_ready response handshake; response held until accepted
//   resp_rdata, resp_err  load result (0 for stores/errors); error flag
//   mem_A, mem_WD         word index and write word to memory
//   mem_MemWrite          memory write enable
//   mem_RD                memory read word, valid the cycle after mem_A
module mem_access_unit #(
  parameter int MEM_BYTES = 4096,
  parameter int DATA_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [31:0]       mem_A,
  output logic [DATA_W-1:0] mem_WD,
  output logic              mem_MemWrite,
  input  logic [DATA_W-1:0] mem_RD
);

  typedef enum logic [2:0] {IDLE, READ, MERGE, WRITE, RESP} state_t;

  localparam logic [31:0] ADDR_LIMIT = 32'(MEM_BYTES);

  state_t state, state_nx;

  // Latched request. dec_q marks the cycle after an accept, in which the
  // latched request is classified and the FSM leaves IDLE.
  logic              dec_q;
  logic              write_q;
  logic              signed_q;
  logic [1:0]        size_q;
  logic [31:0]       addr_q;
  logic [DATA_W-1:0] wdata_q;

  logic req_bad;
  logic word_store;

  assign req_bad = (size_q == 2'b11)
                || (size_q == 2'b01 && addr_q[0])
                || (size_q == 2'b10 && addr_q[1:0] != 2'b00)
                || (addr_q >= ADDR_LIMIT);
  assign word_store = write_q && (size_q == 2'b10);

  assign req_ready    = (state == IDLE) && !dec_q;
  assign resp_valid   = (state == RESP);
  assign mem_MemWrite = (state == WRITE);
  assign mem_A        = {2'b00, addr_q[31:2]};

  // Pick the addressed lane out of a memory word and extend it.
  function automatic logic [DATA_W-1:0] load_extract(
    input logic [1:0]        size,
    input logic              sgn,
    input logic [1:0]        lane,
    input logic [DATA_W-1:0] word
  );
    logic [7:0]        b;
    logic [15:0]       h;
    logic [DATA_W-1:0] r;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      2'b00:   r = {{24{sgn & b[7]}}, b};
      2'b01:   r = {{16{sgn & h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // Replace the addressed lane(s) of the old word with the low store bits.
  function automatic logic [DATA_W-1:0] store_merge(
    input logic [1:0]        size,
    input logic [1:0]        lane,
    input logic [DATA_W-1:0] old_word,
    input logic [DATA_W-1:0] wd
  );
    logic [DATA_W-1:0] r;
    r = old_word;
    case (size)
      2'b00:   r[{lane, 3'b000} +: 8] = wd[7:0];
      2'b01:   if (lane[1]) r[31:16] = wd[15:0];
               else         r[15:0]  = wd[15:0];
      default: r = wd;
    endcase
    return r;
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // NOTE: state_nx gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (dec_q) begin
          if (req_bad)         state_nx = RESP;
          else if (word_store) state_nx = WRITE;
          else                 state_nx = READ;
        end
      end
      READ:    state_nx = MERGE;
      MERGE:   state_nx = write_q ? WRITE : RESP;
      WRITE:   state_nx = RESP;
      RESP:    if (resp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dec_q      <= 1'b0;
      write_q    <= 1'b0;
      signed_q   <= 1'b0;
      size_q     <= 2'b00;
      addr_q     <= '0;
      wdata_q    <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      mem_WD     <= '0;
    end else begin
      if (req_valid && req_ready) begin
        dec_q      <= 1'b1;
        write_q    <= req_write;
        signed_q   <= req_signed;
        size_q     <= req_size;
        addr_q     <= req_addr;
        wdata_q    <= req_wdata;
        resp_rdata <= '0;
        resp_err   <= 1'b0;
      end
      if (dec_q) begin
        dec_q    <= 1'b0;
        resp_err <= req_bad;
        if (!req_bad && word_store) mem_WD <= wdata_q;
      end
      if (state == MERGE) begin
        if (write_q) mem_WD     <= store_merge(size_q, addr_q[1:0], mem_RD, wdata_q);
        else         resp_rdata <= load_extract(size_q, signed_q, addr_q[1:0], mem_RD);
      end
    end
  end

endmodule
